// File: rtl/uart_tx.sv
// +--------------------------------------------------------------------------+
// | uart_tx : UART frame serializer (start, LSB-first data, [parity], stop)   |
// | Optional parity build: define UART_TX_PARITY_EN.  Revision: 1.0           |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [5:0]            r_edge_cnt;
  logic [5:0]            w_edge_next;
  logic [5:0]            w_period_m1;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [BIT_W-1:0]      w_bit_next;
  logic [DATA_WIDTH-1:0] r_data;
  logic [5:0]            r_prescale;
  logic                  w_wrap;
  logic                  w_accept;
  logic                  w_tx_next;

`ifdef UART_TX_PARITY_EN
  logic r_par_en;
  logic r_par_typ;
  logic w_parity;

  assign w_parity = (^r_data) ^ r_par_typ;
`else
  logic w_unused_par;

  assign w_unused_par = PAR_EN ^ PAR_TYP;
`endif

  // A captured prescale of 0 behaves as a 1-clock bit period.
  assign w_period_m1 = (r_prescale == 6'd0) ? 6'd0 : r_prescale - 6'd1;
  assign w_wrap      = (r_edge_cnt == w_period_m1);
  assign w_accept    = (r_state == IDLE) && Data_Valid;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_bit_next   = '0;
    w_tx_next    = 1'b1;
    w_edge_next  = (r_state == IDLE || w_wrap) ? 6'd0 : r_edge_cnt + 6'd1;

    case (r_state)
      IDLE: begin
        if (Data_Valid) w_state_next = START;
      end
      START: begin
        if (w_wrap) w_state_next = DATA;
      end
      DATA: begin
        w_bit_next = r_bit_cnt;
        if (w_wrap) begin
          if (r_bit_cnt == LAST_BIT) begin
            w_bit_next = '0;
`ifdef UART_TX_PARITY_EN
            w_state_next = r_par_en ? PARITY : STOP;
`else
            w_state_next = STOP;
`endif
          end else begin
            w_bit_next = r_bit_cnt + BIT_ONE;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_wrap) w_state_next = STOP;
      end
`endif
      STOP: begin
        if (w_wrap) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase

    // The line is registered, so it is driven from the state being entered.
    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = r_data[w_bit_next];
`ifdef UART_TX_PARITY_EN
      PARITY:  w_tx_next = w_parity;
`endif
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_data     <= '0;
      r_prescale <= '0;
      TX_OUT     <= 1'b1;
      Busy       <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
`endif
    end else begin
      r_edge_cnt <= w_edge_next;
      r_bit_cnt  <= w_bit_next;
      TX_OUT     <= w_tx_next;
      Busy       <= (w_state_next != IDLE);
      if (w_accept) begin
        r_data     <= P_DATA;
        r_prescale <= Prescale;
`ifdef UART_TX_PARITY_EN
        r_par_en   <= PAR_EN;
        r_par_typ  <= PAR_TYP;
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: expected line/busy traces are built from frame rules.
`default_nettype none

module tb_uart_tx;

  localparam int N = 8;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RST;
  logic [N-1:0] P_DATA;
  logic         Data_Valid;
  logic         PAR_EN;
  logic         PAR_TYP;
  logic [5:0]   Prescale;
  logic         TX_OUT;
  logic         Busy;

  int total = 0;
  int bad   = 0;
  int bc;
  bit exp_tx[$];
  bit exp_busy[$];

  uart_tx #(.DATA_WIDTH(N)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .Prescale(Prescale),
    .TX_OUT(TX_OUT), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int frame_len(input bit pe, input int ps);
    int p = (ps == 0) ? 1 : ps;
    return p * (N + 2 + ((PAR_BUILT && pe) ? 1 : 0));
  endfunction

  task automatic push_frame(input logic [N-1:0] d, input bit pe, input bit pt, input int ps);
    int p = (ps == 0) ? 1 : ps;
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < N; i++) bits.push_back(d[i]);
    // Even parity: total ones (data + parity) even; odd parity inverts it.
    if (PAR_BUILT && pe) bits.push_back((($countones(d) % 2) == 1) ^ pt);
    bits.push_back(1'b1);
    foreach (bits[k]) begin
      for (int j = 0; j < p; j++) begin
        exp_tx.push_back(bits[k]);
        exp_busy.push_back(1'b1);
      end
    end
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) begin
      exp_tx.push_back(1'b1);
      exp_busy.push_back(1'b0);
    end
  endtask

  // mode 0: drop valid, scramble inputs; 1: mid-frame 0xFF pulse; 2: valid held, back-to-back
  task automatic drain(input string name, input int mode, input int l1, output int busy_cnt);
    int  tx_bad = 0;
    int  busy_bad = 0;
    int  first = -1;
    logic got = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < exp_tx.size(); i++) begin
      @(posedge CLK); #1;
      if (Busy === 1'b1) busy_cnt++;
      if (TX_OUT !== exp_tx[i]) begin
        tx_bad++;
        if (first < 0) begin
          first = i;
          got   = TX_OUT;
        end
      end
      if (Busy !== exp_busy[i]) busy_bad++;
      case (mode)
        0: if (i == 0) begin
             Data_Valid = 1'b0;
             P_DATA     = N'($urandom);
             PAR_EN     = 1'($urandom);
             PAR_TYP    = 1'($urandom);
             Prescale   = 6'($urandom);
           end
        1: begin
             if (i == 0) Data_Valid = 1'b0;
             if (i == l1 / 2) begin
               P_DATA     = 8'hFF;
               Data_Valid = 1'b1;
             end
             if (i == l1 / 2 + 1) Data_Valid = 1'b0;
           end
        default: begin
             if (i == 0) P_DATA = 8'hFF;
             if (i == l1) P_DATA = 8'h96;
             if (i == l1 + 1) begin
               Data_Valid = 1'b0;
               P_DATA     = 8'hFF;
             end
           end
      endcase
    end
    total++;
    if (tx_bad !== 0) begin
      bad++;
      $display("FAIL %s tx_trace: %0d wrong cycles, first at cycle %0d got %b expected %b",
               name, tx_bad, first, got, exp_tx[first]);
    end
    total++;
    if (busy_bad !== 0) begin
      bad++;
      $display("FAIL %s busy_trace: %0d wrong cycles (got busy count %0d)", name, busy_bad, busy_cnt);
    end
    exp_tx.delete();
    exp_busy.delete();
  endtask

  task automatic check_len(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s busy_len: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic check_idle(input string name);
    total++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      bad++;
      $display("FAIL %s idle: got TX_OUT=%b Busy=%b expected TX_OUT=1 Busy=0", name, TX_OUT, Busy);
    end
  endtask

  task automatic start_frame(input logic [N-1:0] d, input bit pe, input bit pt, input int ps);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Prescale   = 6'(ps);
    Data_Valid = 1'b1;
  endtask

  task automatic test_reset;
    RST = 1'b0; start_frame(8'hA5, 1'b0, 1'b0, 8);
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK); #1;
      check_idle("reset_hold");
    end
    RST = 1'b1; Data_Valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK); #1;
      check_idle("reset_release");
    end
  endtask

  task automatic test_basic;
    start_frame(8'hA5, 1'b0, 1'b0, 8);
    push_frame(8'hA5, 1'b0, 1'b0, 8); push_idle(2);
    drain("basic", 0, 0, bc);
    check_len("basic", bc, 80);
  endtask

  task automatic test_parity;
    for (int t = 0; t < 2; t++) begin
      start_frame(8'hA5, 1'b1, 1'(t), 8);
      push_frame(8'hA5, 1'b1, 1'(t), 8); push_idle(2);
      drain(t == 0 ? "parity_even" : "parity_odd", 0, 0, bc);
      check_len("parity", bc, PAR_BUILT ? 88 : 80);
    end
  endtask

  task automatic test_busy_reject;
    start_frame(8'h3C, 1'b0, 1'b0, 4);
    push_frame(8'h3C, 1'b0, 1'b0, 4); push_idle(3);
    drain("busy_reject", 1, 40, bc);
    check_len("busy_reject", bc, 40);
  endtask

  task automatic test_back_to_back;
    start_frame(8'h3C, 1'b0, 1'b0, 3);
    push_frame(8'h3C, 1'b0, 1'b0, 3); push_idle(1);
    push_frame(8'h96, 1'b0, 1'b0, 3); push_idle(2);
    drain("back_to_back", 2, 30, bc);
    check_len("back_to_back", bc, 60);
  endtask

  task automatic test_midframe_reset;
    start_frame(8'h00, 1'b0, 1'b0, 4);
    for (int i = 0; i <= 3 * 4 + 1; i++) begin
      @(posedge CLK); #1;
      if (i == 0) Data_Valid = 1'b0;
    end
    RST = 1'b0;
    @(posedge CLK); #1;
    check_idle("midframe_reset");
    RST = 1'b1;
    @(posedge CLK); #1;
    check_idle("after_reset");
    start_frame(8'h55, 1'b0, 1'b0, 4);
    push_frame(8'h55, 1'b0, 1'b0, 4); push_idle(2);
    drain("post_reset_frame", 0, 0, bc);
    check_len("post_reset_frame", bc, 40);
  endtask

  task automatic test_min_prescale;
    for (int ps = 1; ps >= 0; ps--) begin
      start_frame(8'h81, 1'b0, 1'b0, ps);
      push_frame(8'h81, 1'b0, 1'b0, ps); push_idle(2);
      drain(ps == 1 ? "prescale_1" : "prescale_0", 0, 0, bc);
      check_len("min_prescale", bc, 10);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 12; n++) begin
      logic [N-1:0] d  = N'($urandom);
      bit           pe = 1'($urandom);
      bit           pt = 1'($urandom);
      int           ps = $urandom_range(0, 6);
      start_frame(d, pe, pt, ps);
      push_frame(d, pe, pt, ps); push_idle(1 + $urandom_range(0, 2));
      drain("random", 0, 0, bc);
      check_len("random", bc, frame_len(pe, ps));
    end
  endtask

  initial begin
    RST = 1'b0; Data_Valid = 1'b0; P_DATA = '0;
    PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd8;
    test_reset;
    test_basic;
    test_parity;
    test_busy_reject;
    test_back_to_back;
    test_midframe_reset;
    test_min_prescale;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
